// File: rtl/ft245_sync_bus_arbiter_if.sv
// FT245-synchronous bus plus streamer/command-sink handshakes, grouped as one bundle.
interface ft245_sync_bus_arbiter_if;
  logic       rxf_n_i;
  logic       txe_n_i;
  logic       rd_n_o;
  logic       wr_n_o;
  logic       oe_n_o;
  logic       adbus_oe_o;
  logic [7:0] adbus_i;
  logic [7:0] adbus_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_afull_i;
  logic [2:0] state_o;

  // Arbiter side: owns the FT bus strobes and the streamer/sink handshakes.
  modport master (
    input  rxf_n_i, txe_n_i, adbus_i, tx_data_i, tx_valid_i, rx_afull_i,
    output rd_n_o, wr_n_o, oe_n_o, adbus_oe_o, adbus_o, tx_ready_o,
           rx_data_o, rx_valid_o, state_o
  );

  // Environment side: FT2232H pins, streamer and command sink.
  modport slave (
    output rxf_n_i, txe_n_i, adbus_i, tx_data_i, tx_valid_i, rx_afull_i,
    input  rd_n_o, wr_n_o, oe_n_o, adbus_oe_o, adbus_o, tx_ready_o,
           rx_data_o, rx_valid_o, state_o
  );
endinterface

// File: rtl/ft245_sync_bus_arbiter.sv
// FT2232H FT245-synchronous bus owner: fair, bounded-burst arbitration between
// host-command reads (RX) and streamer writes (TX), with OE#/RD#/WR# sequencing
// and a turnaround cycle after every read burst.
module ft245_sync_bus_arbiter #(
  parameter int unsigned RX_BURST_MAX = 64,
  parameter int unsigned TX_BURST_MAX = 512
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  ft245_sync_bus_arbiter_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_OE    = 3'd1,
    RX_READ  = 3'd2,
    RX_TURN  = 3'd3,
    TX_WRITE = 3'd4
  } state_t;

  localparam logic [7:0]  RX_LAST = 8'(RX_BURST_MAX - 1);
  localparam logic [15:0] TX_LAST = 16'(TX_BURST_MAX - 1);

  state_t      state_q, state_d;
  logic        rd_n_q, oe_n_q, adbus_oe_q;
  logic        rx_valid_q;
  logic [7:0]  rx_data_q;
  logic [7:0]  rx_cnt_q;
  logic [15:0] tx_cnt_q;
  logic        last_tx_q;   // 1 = most recent grant went to TX

  logic rx_req, tx_req, grant_rx, grant_tx;
  logic rx_cap, rx_last, tx_xfer, tx_last;

  // Request qualification, per-cycle transfer detection and next-state selection.
  always_comb begin
    rx_req   = ~bus.rxf_n_i & ~bus.rx_afull_i;
    tx_req   = ~bus.txe_n_i & bus.tx_valid_i;
    // On contention, hand the bus to whichever side did not have it last.
    grant_rx = rx_req & (~tx_req | last_tx_q);
    grant_tx = tx_req & ~grant_rx;
    rx_cap   = ~rd_n_q & ~bus.rxf_n_i;
    rx_last  = rx_cap & (rx_cnt_q == RX_LAST);
    tx_xfer  = (state_q == TX_WRITE) & bus.tx_valid_i & ~bus.txe_n_i;
    tx_last  = tx_xfer & (tx_cnt_q == TX_LAST);
    state_d  = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_rx)      state_d = RX_OE;
        else if (grant_tx) state_d = TX_WRITE;
      end
      RX_OE:    state_d = RX_READ;
      RX_READ:  if (bus.rxf_n_i | rx_last) state_d = RX_TURN;
      RX_TURN:  state_d = IDLE;
      TX_WRITE: if (~tx_xfer | tx_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, registered strobes (loaded from next state), RX capture and burst counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rd_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      adbus_oe_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      last_tx_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      rd_n_q     <= (state_d != RX_READ);
      oe_n_q     <= ~((state_d == RX_OE) | (state_d == RX_READ));
      adbus_oe_q <= (state_d == TX_WRITE);
      rx_valid_q <= rx_cap;
      if (rx_cap) rx_data_q <= bus.adbus_i;
      if (state_q == IDLE && grant_rx) begin
        rx_cnt_q  <= '0;
        last_tx_q <= 1'b0;
      end else if (rx_cap) begin
        rx_cnt_q  <= rx_cnt_q + 8'd1;
      end
      if (state_q == IDLE && grant_tx) begin
        tx_cnt_q  <= '0;
        last_tx_q <= 1'b1;
      end else if (tx_xfer) begin
        tx_cnt_q  <= tx_cnt_q + 16'd1;
      end
    end
  end

  assign bus.rd_n_o     = rd_n_q;
  assign bus.oe_n_o     = oe_n_q;
  assign bus.adbus_oe_o = adbus_oe_q;
  assign bus.wr_n_o     = ~((state_q == TX_WRITE) & bus.tx_valid_i);
  assign bus.adbus_o    = bus.tx_data_i;
  assign bus.tx_ready_o = (state_q == TX_WRITE) & ~bus.txe_n_i;
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.state_o    = state_q;

endmodule
